// File: rtl/fft_sample_framer_if.sv
// Sample-in / word-out bundle of the FFT sample framer.
// The master modport is the framer's view; the slave modport is the source/sink side.
`timescale 1ns/1ps
interface fft_sample_framer_if #(
    parameter int DATA_W = 12
);
    logic              i_sample_tick;
    logic [DATA_W-1:0] i_sample;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic [3:0]        o_index;
    logic              o_last;
    logic              o_filling;
    logic              o_overrun;
    logic [7:0]        o_frame_cnt;

    modport master (
        input  i_sample_tick, i_sample, i_ready,
        output o_valid, o_data, o_index, o_last, o_filling, o_overrun, o_frame_cnt
    );

    modport slave (
        output i_sample_tick, i_sample, i_ready,
        input  o_valid, o_data, o_index, o_last, o_filling, o_overrun, o_frame_cnt
    );
endinterface

// File: rtl/fft_sample_framer.sv
// Buffers one 16-point frame paced by a divided-clock tick, then streams it out over valid/ready.
// Define FRAMER_BITREV_EN to emit the frame in bit-reversed address order; otherwise natural order.
`timescale 1ns/1ps
module fft_sample_framer #(
    parameter int DATA_W = 12,
    parameter int N_PTS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fft_sample_framer_if.master  bus
);
    localparam int ADDR_W = $clog2(N_PTS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PTS - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              tick_q;
    logic              tick_edge;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              wr_en;
    logic [DATA_W-1:0] mem [N_PTS];

    // The tick is a level from the divider, so it is edge-detected rather than used as a clock.
    assign tick_edge = bus.i_sample_tick & ~tick_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_q      <= 1'b1;
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            tick_q      <= bus.i_sample_tick;
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_cnt_q] <= bus.i_sample;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        case (state_q)
            FILL: begin
                if (tick_edge) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Single buffer: a sample slot during the drain is lost, even on the final handshake.
                if (tick_edge) begin
                    overrun_d = 1'b1;
                end
                if (bus.i_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_ADDR) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

`ifdef FRAMER_BITREV_EN
    assign rd_addr = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2], rd_cnt_q[3]};
`else
    assign rd_addr = rd_cnt_q;
`endif

    always_comb begin
        bus.o_valid     = (state_q == DRAIN);
        bus.o_data      = mem[rd_addr];
        bus.o_index     = rd_addr;
        bus.o_last      = (state_q == DRAIN) && (rd_cnt_q == LAST_ADDR);
        bus.o_filling   = (state_q == FILL);
        bus.o_overrun   = overrun_q;
        bus.o_frame_cnt = frame_cnt_q;
    end
endmodule
